// File: rtl/pipe_dmem_arbiter.sv
// Purpose : shares the single-port data RAM between the CPU MEM stage and a DMA/loader port.
// Latency : request seen in IDLE at T0 -> mem_en at T1 -> ack (and read data) at T0+MEM_LAT+2.
// Backpr. : one access in flight; the other requester waits on its level req, CPU sees cpu_stall.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request (level, held until cpu_ack); cpu_rdata/cpu_ack back
//   cpu_stall             cpu_req & ~cpu_ack
//   dma_req/we/addr/wdata DMA request (level, held until dma_ack); dma_rdata/dma_ack back
//   mem_en/we/addr/wdata  RAM command, mem_en high exactly one cycle per access
//   mem_rdata             RAM read data, valid MEM_LAT cycles after mem_en
//   busy                  high whenever the arbiter is not IDLE
// Optional: define ARB_PERF_CNT_EN to add stall_cnt and dma_grant_cnt outputs.

module pipe_dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   dma_grant_cnt
`endif
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("pipe_dmem_arbiter: MEM_LAT=%0d is outside the legal range 1..4", MEM_LAT);
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic            acc_we_q, acc_we_d;
  logic [2:0]      lat_cnt_q, lat_cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            dma_ack_q, dma_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            busy_q, busy_d;

  // DMA wins only when it is alone, or on a tie when the CPU owned the previous access.
  logic grant_dma;
  assign grant_dma = dma_req & (~cpu_req | (last_owner_q == OWN_CPU));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    acc_we_d     = acc_we_q;
    lat_cnt_d    = lat_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          // The RAM command registers double as the latched request, so
          // they already hold the access when ISSUE drives mem_en.
          owner_d      = grant_dma;
          last_owner_d = grant_dma;
          acc_we_d     = grant_dma ? dma_we : cpu_we;
          mem_addr_d   = grant_dma ? dma_addr : cpu_addr;
          mem_wdata_d  = grant_dma ? dma_wdata : cpu_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_dma ? dma_we : cpu_we;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_cnt_d = 3'(MEM_LAT);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        // Counter hits zero on this edge: RAM data is valid now.
        if (lat_cnt_q == 3'd1) begin
          if (!acc_we_q) begin
            if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          cpu_ack_d = (owner_q == OWN_CPU);
          dma_ack_d = (owner_q == OWN_DMA);
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // No arbitration here: the owner's req is still high this cycle.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_DMA;
      last_owner_q <= OWN_DMA;
      acc_we_q     <= 1'b0;
      lat_cnt_q    <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      acc_we_q     <= acc_we_d;
      lat_cnt_q    <= lat_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = busy_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] dma_grant_cnt_q, dma_grant_cnt_d;

  always_comb begin
    stall_cnt_d     = stall_cnt_q + {31'd0, cpu_stall};
    dma_grant_cnt_d = dma_grant_cnt_q + {31'd0, (state_q == S_IDLE) & grant_dma};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q     <= 32'd0;
      dma_grant_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      dma_grant_cnt_q <= dma_grant_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign dma_grant_cnt = dma_grant_cnt_q;
`endif

endmodule
